// File: rtl/apb_pkg.sv
// Shared APB definitions: bus widths, completer FSM states and the
// command encoding shared with the APB master.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   localparam logic [1:0] APB_CMD_IDLE  = 2'b00;
   localparam logic [1:0] APB_CMD_READ  = 2'b01;
   localparam logic [1:0] APB_CMD_WRITE = 2'b10;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   // Wait counter width: enough bits to hold WAIT_CYCLES, never 0.
   function automatic int cnt_width(input int wait_cycles);
      return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
   endfunction

endpackage

// File: rtl/apb_wait_counter.sv
// Loadable down-counter with zero flag, used for access-phase wait states.
// Ports: clk, reset (sync, active-low), load_i/load_val_i, dec_i, zero_o.
module apb_wait_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         zero_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer: NUM_REGS x 32-bit R/W register bank with fixed wait states.
// Ports: clk, reset (sync, active-low), APB psel/penable/paddr/pwrite/pwdata
// inputs; pready/prdata/pslverr outputs.
module apb_slave_regfile
   import apb_pkg::*;
#(
   parameter int unsigned    NUM_REGS    = 16,
   parameter int unsigned    WAIT_CYCLES = 2,
   parameter logic [31:0]    BASE_ADDR   = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic [APB_ADDR_W-1:0] paddr_i,
   input  logic                  pwrite_i,
   input  logic [APB_DATA_W-1:0] pwdata_i,
   output logic                  pready_o,
   output logic [APB_DATA_W-1:0] prdata_o,
   output logic                  pslverr_o
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int CNT_W = cnt_width(int'(WAIT_CYCLES));
   localparam logic [APB_ADDR_W-1:0] SPAN = APB_ADDR_W'(4 * NUM_REGS);

   apb_state_e state_q, state_d;

   logic [APB_ADDR_W-1:0] addr_q, addr_d;
   logic                  write_q, write_d;
   logic [APB_DATA_W-1:0] wdata_q, wdata_d;
   logic [APB_DATA_W-1:0] regs_q [NUM_REGS];

   logic                  cap;
   logic                  cnt_load;
   logic                  cnt_dec;
   logic                  cnt_zero;
   logic [APB_ADDR_W-1:0] offset;
   logic [IDX_W-1:0]      idx;
   logic                  in_range;
   logic                  wr_en;

   apb_wait_counter #(
      .W (CNT_W)
   ) u_wait (
      .clk        (clk),
      .reset      (reset),
      .load_i     (cnt_load),
      .load_val_i (CNT_W'(WAIT_CYCLES)),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

   // Decode from the captured address so bus changes mid-access are ignored.
   assign offset   = addr_q - BASE_ADDR;
   assign idx      = offset[2 +: IDX_W];
   assign in_range = (offset[1:0] == 2'b00) && (offset < SPAN);

   assign pready_o = (state_q == ACCESS) && cnt_zero
                     && psel_i && penable_i;
   assign pslverr_o = pready_o && !in_range;
   assign prdata_o  = (pready_o && !write_q && in_range)
                      ? regs_q[idx] : '0;
   assign wr_en     = pready_o && write_q && in_range;

   always_comb begin
      state_d  = state_q;
      cap      = 1'b0;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (psel_i && !penable_i) begin
               state_d  = ACCESS;
               cap      = 1'b1;
               cnt_load = 1'b1;
            end
         end
         ACCESS: begin
            if (!psel_i) begin
               state_d = IDLE;
            end else if (pready_o) begin
               state_d = IDLE;
            end else if (penable_i) begin
               cnt_dec = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      if (cap) begin
         addr_d  = paddr_i;
         write_d = pwrite_i;
         wdata_d = pwdata_i;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs_q[i] <= '0;
         end
      end else if (wr_en) begin
         regs_q[idx] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile (WAIT_CYCLES=2 and WAIT_CYCLES=0).
// Stimulus pushes expected responses; per-DUT monitors pop on pready.
module tb_apb_slave_regfile;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        dsel = 1'b0;
   logic [31:0] paddr = '0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;

   logic        psel2, psel0;
   logic        pready2, pslverr2, pready0, pslverr0;
   logic [31:0] prdata2, prdata0;

   exp_t q2[$];
   exp_t q0[$];
   int   ncmp = 0;
   int   nerr = 0;
   int   acnt2 = 0;
   int   acnt0 = 0;

   always #5 clk = ~clk;

   assign psel2 = psel && !dsel;
   assign psel0 = psel && dsel;

   apb_slave_regfile #(
      .NUM_REGS    (16),
      .WAIT_CYCLES (2),
      .BASE_ADDR   (32'h0000_0000)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .psel_i    (psel2),
      .penable_i (penable),
      .paddr_i   (paddr),
      .pwrite_i  (pwrite),
      .pwdata_i  (pwdata),
      .pready_o  (pready2),
      .prdata_o  (prdata2),
      .pslverr_o (pslverr2)
   );

   apb_slave_regfile #(
      .NUM_REGS    (16),
      .WAIT_CYCLES (0),
      .BASE_ADDR   (32'h0000_0000)
   ) dut0 (
      .clk       (clk),
      .reset     (reset),
      .psel_i    (psel0),
      .penable_i (penable),
      .paddr_i   (paddr),
      .pwrite_i  (pwrite),
      .pwdata_i  (pwdata),
      .pready_o  (pready0),
      .prdata_o  (prdata0),
      .pslverr_o (pslverr0)
   );

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pop_cmp(input int which, input logic [31:0] rd,
                          input logic err, input int lat);
      exp_t e;
      if (which == 0) begin
         if (q2.size() == 0) begin
            check("w2_unexpected_pready", 32'd1, 32'd0);
            return;
         end
         e = q2.pop_front();
      end else begin
         if (q0.size() == 0) begin
            check("w0_unexpected_pready", 32'd1, 32'd0);
            return;
         end
         e = q0.pop_front();
      end
      check("prdata", rd, e.rd);
      check("pslverr", {31'd0, err}, {31'd0, e.err});
      check("latency", lat, e.lat);
   endtask

   always @(negedge clk) begin
      if (psel2 && penable) begin
         acnt2++;
         if (pready2) begin
            pop_cmp(0, prdata2, pslverr2, acnt2);
            acnt2 = 0;
         end
      end else begin
         acnt2 = 0;
      end
   end

   always @(negedge clk) begin
      if (psel0 && penable) begin
         acnt0++;
         if (pready0) begin
            pop_cmp(1, prdata0, pslverr0, acnt0);
            acnt0 = 0;
         end
      end else begin
         acnt0 = 0;
      end
   end

   function automatic logic rdy(input logic s);
      return s ? pready0 : pready2;
   endfunction

   task automatic xfer(input logic s, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] erd,
                       input logic eerr, input int elat);
      exp_t e;
      int   n;
      e.rd  = erd;
      e.err = eerr;
      e.lat = elat;
      @(posedge clk);
      #1;
      if (s) q0.push_back(e);
      else   q2.push_back(e);
      dsel    = s;
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = a;
      pwrite  = w;
      pwdata  = d;
      @(posedge clk);
      #1;
      penable = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy(s) && n < 20);
      if (!rdy(s)) check("xfer_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_pready", {31'd0, pready2}, 32'd0);
      check("rst_prdata", prdata2, 32'd0);
      check("rst_pslverr", {31'd0, pslverr2}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      xfer(1'b0, 1'b0, 32'h0C, 32'h0, 32'h0, 1'b0, 3);
      idle();

      xfer(1'b0, 1'b1, 32'h08, 32'hDEAD_BEEF, 32'h0, 1'b0, 3);
      xfer(1'b0, 1'b0, 32'h08, 32'h0, 32'hDEAD_BEEF, 1'b0, 3);
      idle();

      xfer(1'b1, 1'b1, 32'h3C, 32'h5, 32'h0, 1'b0, 1);
      xfer(1'b1, 1'b0, 32'h3C, 32'h0, 32'h5, 1'b0, 1);
      idle();

      xfer(1'b0, 1'b1, 32'h00, 32'h1111, 32'h0, 1'b0, 3);
      xfer(1'b0, 1'b1, 32'h40, 32'h1234, 32'h0, 1'b1, 3);
      xfer(1'b0, 1'b1, 32'h02, 32'h1234, 32'h0, 1'b1, 3);
      xfer(1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 3);
      xfer(1'b0, 1'b0, 32'h00, 32'h0, 32'h1111, 1'b0, 3);
      idle();

      // master abort in the 2nd access cycle of a write to reg1
      @(posedge clk);
      #1;
      dsel    = 1'b0;
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = 32'h04;
      pwrite  = 1'b1;
      pwdata  = 32'hAAAA;
      @(posedge clk);
      #1;
      penable = 1'b1;
      @(posedge clk);
      #1;
      psel    = 1'b0;
      penable = 1'b0;
      @(negedge clk);
      check("abort_pready", {31'd0, pready2}, 32'd0);
      xfer(1'b0, 1'b0, 32'h04, 32'h0, 32'h0, 1'b0, 3);
      idle();

      // reset mid-access of a write, after reg2 holds 0x77
      xfer(1'b0, 1'b1, 32'h08, 32'h77, 32'h0, 1'b0, 3);
      xfer(1'b0, 1'b0, 32'h08, 32'h0, 32'h77, 1'b0, 3);
      @(posedge clk);
      #1;
      psel    = 1'b1;
      penable = 1'b0;
      paddr   = 32'h08;
      pwrite  = 1'b1;
      pwdata  = 32'h99;
      @(posedge clk);
      #1;
      penable = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("midrst_pready", {31'd0, pready2}, 32'd0);
      check("midrst_prdata", prdata2, 32'd0);
      check("midrst_pslverr", {31'd0, pslverr2}, 32'd0);
      @(posedge clk);
      #1;
      reset   = 1'b1;
      psel    = 1'b0;
      penable = 1'b0;
      xfer(1'b0, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0, 3);
      idle();

      repeat (3) @(negedge clk);
      check("q2_drained", q2.size(), 32'd0);
      check("q0_drained", q0.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/apb_slave_regfile.md
Name: apb_slave_regfile

Overview:
- APB completer (responder) for the existing APB master: a bank of NUM_REGS 32-bit read/write registers behind a fixed, parameterised number of wait states.
- Decodes the master's setup/access phases and drives pready_o, prdata_o and pslverr_o.
- It is the default peripheral the master drives in system-level sims. It also serves as the reference completer model for stretching the master's wait-state handling.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; power of two, ≥2.
- WAIT_CYCLES, 2, access-phase wait states inserted before pready_o; 0 means zero-wait.
- BASE_ADDR, 32'h0000_0000, byte base address of the register bank.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- psel_i  input  1  select from master.
- penable_i  input  1  access-phase indicator.
- paddr_i  input  32  byte address.
- pwrite_i  input  1  1 = write, 0 = read.
- pwdata_i  input  32  write data.
- pready_o  output  1  transfer complete.
- prdata_o  output  32  read data, valid only while pready_o=1 on a read.
- pslverr_o  output  1  error, valid only while pready_o=1.

Behaviour:
- Address decode:
  - offset = paddr_i − BASE_ADDR.
  - idx = offset[2 +: log2(NUM_REGS)].
  - A transfer is in range only if offset[1:0]==0 and offset < 4*NUM_REGS; otherwise it is an error.
- FSM states: IDLE, ACCESS. A wait counter cnt is log2(WAIT_CYCLES+1) bits wide, minimum 1.
- IDLE:
  - At a clk edge with psel_i=1 and penable_i=0 (setup phase), capture paddr_i, pwrite_i and pwdata_i; load cnt=WAIT_CYCLES; go to ACCESS.
  - psel_i=1 with penable_i=1 while in IDLE (no prior setup) is ignored: stay in IDLE, pready_o=0.
- ACCESS:
  - pready_o = (state==ACCESS) && (cnt==0) && psel_i && penable_i. This is combinational from registers and inputs, so access-phase length is exactly WAIT_CYCLES+1 cycles.
  - While cnt≠0 and psel_i&&penable_i: cnt decrements by 1 per cycle.
  - At the edge where pready_o=1:
    - Write in range: reg[idx] <= captured pwdata.
    - Return to IDLE. A setup phase on the very next cycle is accepted normally (back-to-back transfers; no dead cycle required).
  - psel_i=0 while in ACCESS (master abort): go to IDLE, no register update, pready_o=0.
- Read data: prdata_o = reg[idx] when pready_o=1, pwrite=0 and in range; 32'h0 in all other cycles.
- Errors:
  - pslverr_o = pready_o && out_of_range.
  - An out-of-range write is dropped; an out-of-range read returns 0.
  - Wait states are still inserted for error transfers.
- Captured address and direction are used throughout ACCESS. Changes on paddr_i or pwrite_i during ACCESS are ignored.
- Reset (reset==0 at an edge), including mid-transfer:
  - state=IDLE, cnt=0, all registers 32'h0.
  - Outputs pready_o=0, prdata_o=0, pslverr_o=0 from the following cycle.
- pready_o never asserts in two consecutive cycles for one transfer.

Decomposition:
- Shared package apb_pkg:
  - state enum {IDLE, ACCESS}
  - APB_ADDR_W=32, APB_DATA_W=32
  - APB_CMD_IDLE=2'b00, APB_CMD_READ=2'b01, APB_CMD_WRITE=2'b10, shared with the master
- Sub-module apb_wait_counter: loadable down-counter with a zero flag. It is the only natural split; the register array and decode stay in the top.

Test Plan:
- Reset then read idx 3 (paddr=32'h0C), WAIT_CYCLES=2 -> pready_o high on the 3rd access cycle; prdata_o=32'h0, pslverr_o=0.
- Write 32'hDEAD_BEEF to 32'h08, then read 32'h08 back-to-back with no idle cycle -> the read returns 32'hDEAD_BEEF; each transfer takes 1 setup + 3 access cycles.
- WAIT_CYCLES=0: write 32'h5 to 32'h3C, read it back -> pready_o high in the first access cycle of each; prdata_o=32'h5.
- Write 32'h1234 to 32'h40 (out of range) and to 32'h02 (misaligned) -> pslverr_o=1 with pready_o. A subsequent read of idx 0 returns its prior value unchanged.
- Drop psel_i in the 2nd access cycle of a write of 32'hAAAA to 32'h04 -> no pready_o, reg1 unchanged; the next setup is accepted normally.
- Assert reset=0 mid-ACCESS of a write after reg2 was set to 32'h77 -> pready_o=0 next cycle; after release, a read of 32'h08 returns 32'h0.
